axi_arbiter_2to1: RTL and testbench
===================================

# axi_arbiter_2to1

Two-to-one AXI4 arbiter that shares a single AXI4 master port between two requesting masters (for example, two `axi_master` instances) and a downstream slave or interconnect port. Read (AR/R) and write (AW/W/B) paths are arbitrated independently with round-robin priority. A grant is held for the whole burst: from address handshake through the `rlast` beat on reads, and through the B response on writes. It sits between the requesting masters and the memory-side slave.

## Interface

- `DEFAULT_PRIO`, default 0: requester (0 or 1) that wins a simultaneous request after reset.
- `aclk`  in  1  clock; single clock domain.
- `areset_n`  in  1  synchronous, active-low reset.
- `s0_axi`  `axi_if.slave`  bundle  requester 0 (full AR, R, AW, W, B channel set).
- `s1_axi`  `axi_if.slave`  bundle  requester 1.
- `m_axi`  `axi_if.master`  bundle  shared downstream port.
- `rd_busy`  out  1  read path is not in R_IDLE.
- `rd_owner`  out  1  current or last read grant index.
- `wr_busy`  out  1  write path is not in W_IDLE.
- `wr_owner`  out  1  current or last write grant index.

## Operation

**Read FSM: R_IDLE, R_ADDR, R_DATA**
- **R_IDLE**
  - If any `sX.arvalid` is asserted, register the grant:
    - Only one requester valid: that requester wins.
    - Both valid: `rd_prio` wins.
  - Go to R_ADDR.
- **R_ADDR**
  - `m_axi.ar*` = granted `ar*` (`araddr`, `arlen`, `arsize`, `arburst`, `arvalid`).
  - Granted `arready` = `m_axi.arready`.
  - On `m_axi` AR handshake, go to R_DATA.
- **R_DATA**
  - Granted requester receives `rdata`, `rresp`, `rlast`, `rvalid`.
  - `m_axi.rready` = granted `rready`.
  - On a handshake with `rlast`=1:
    - Go to R_IDLE.
    - `rd_prio` <= ~granted.

**Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP**
- Arbitration on `awvalid` is identical to the read path, using `wr_prio`.
- **W_ADDR** forwards AW.
- **W_DATA** forwards W (`wdata`, `wstrb`, `wlast`, `wvalid` to `m_axi`; `wready` to the granted requester).
  - Leaves on a handshake with `wlast`=1.
- **W_RESP** forwards B.
  - On the B handshake:
    - Go to W_IDLE.
    - `wr_prio` <= ~granted.

**Forwarding rules**
- W data is forwarded only in W_DATA. A requester presenting `wvalid` early is stalled (`wready`=0) until W_DATA.
- Non-granted requester, and any requester while its path is idle:
  - `arready`, `awready`, `wready` = 0.
  - `rvalid`, `bvalid` = 0.
  - `rdata` = 0, `rlast` = 0.
- `m_axi` outputs when a path is idle:
  - `arvalid`, `awvalid`, `wvalid` = 0.
  - `rready`, `bready` = 0.
  - Address and data fields = 0.
- Read and write paths may be owned by different requesters at the same time. The two paths do not interact.

## Timing

**Reset**
- Both FSMs go to IDLE.
- `rd_prio` = `wr_prio` = `DEFAULT_PRIO`.
- Grants = `DEFAULT_PRIO`, so `rd_owner` = `wr_owner` = `DEFAULT_PRIO`.
- `rd_busy` = `wr_busy` = 0.
- All forwarded valids and readies = 0.
- Reset mid-burst abandons the burst immediately. There is no drain.

**Latency and handshakes**
- Arbitration latency is 1 cycle: a valid sampled in IDLE at edge N gives `m_axi.*valid`=1 during cycle N+1.
- ARREADY, AWREADY, WREADY, RVALID and BVALID are combinational pass-throughs in the owning state. No added latency per beat.
- A requester's `*valid` must remain asserted while it is not granted (AXI rule). The arbiter never drops a pending request.
- After the final handshake, the FSM is in IDLE for exactly 1 cycle before the next grant.
- The maximum bus turnaround between bursts is therefore 1 idle cycle.

**Boundary cases**
- Simultaneous requests: the winner is given by the priority bit. Back-to-back contention alternates 0, 1, 0, 1.
- A single requester repeatedly requesting is re-granted every burst. The priority bit toggles but is unused.
- `arlen`=0 (single beat): R_DATA exits on the first beat, which carries `rlast`=1.
- `bresp` and `rresp` values are forwarded unmodified. Error responses do not affect arbitration.

## Test plan

- **Single read**
  - Stimulus: reset; s0 issues AR `araddr`=0x4, `arlen`=3; slave returns 4 beats 0xA0..0xA3.
  - Required response:
    - `m_axi.arvalid` rises 1 cycle after s0 `arvalid`.
    - s0 receives 0xA0..0xA3, `rlast` on beat 4.
    - s1 sees `rvalid`=0 throughout.
    - `rd_busy` returns to 0.
- **Simultaneous reads**
  - Stimulus: s0 and s1 both assert `arvalid` in the same cycle, twice.
  - Required response:
    - Grant order is s0, s1, s0, s1 (with `DEFAULT_PRIO`=0).
    - Each burst completes before the next AR appears on `m_axi`.
- **Write burst with early W**
  - Stimulus: s1 writes 4 beats 0xDEADBEEF..+3, with `wvalid` asserted together with `awvalid`.
  - Required response:
    - s1 `wready`=0 until the AW handshake.
    - 4 beats forwarded in order; `wlast` on beat 4.
    - `bresp`=OKAY returned to s1 only.
- **Concurrent read and write**
  - Stimulus: s0 reads while s1 writes.
  - Required response:
    - Both paths are active in the same cycles.
    - `rd_owner`=0, `wr_owner`=1.
    - No beats are cross-routed.
- **Reset mid-burst**
  - Stimulus: deassert `areset_n` during beat 2 of an s1 read.
  - Required response:
    - Next cycle: both FSMs idle; all valids and readies 0.
    - `rd_owner` = `DEFAULT_PRIO`.
    - A new s1 request is then granted normally.

Source files
------------

// File: rtl/axi_arbiter_2to1_if.sv
// rtl/axi_arbiter_2to1_if.sv - AXI4 channel bundle shared by the arbiter ports
interface axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_arbiter_2to1.sv
// rtl/axi_arbiter_2to1.sv - round-robin 2:1 AXI4 arbiter, independent read and write paths
module axi_arbiter_2to1 #(
  parameter bit DEFAULT_PRIO = 1'b0
) (
  input  logic  aclk,
  input  logic  areset_n,
  axi_if.slave  s0_axi,
  axi_if.slave  s1_axi,
  axi_if.master m_axi,
  output logic  rd_busy,
  output logic  rd_owner,
  output logic  wr_busy,
  output logic  wr_owner
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_state_nxt;
  wr_state_t wr_state, wr_state_nxt;
  logic rd_grant, rd_grant_nxt, rd_prio, rd_prio_nxt;
  logic wr_grant, wr_grant_nxt, wr_prio, wr_prio_nxt;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rd_state <= R_IDLE;
      rd_grant <= DEFAULT_PRIO;
      rd_prio  <= DEFAULT_PRIO;
      wr_state <= W_IDLE;
      wr_grant <= DEFAULT_PRIO;
      wr_prio  <= DEFAULT_PRIO;
    end else begin
      rd_state <= rd_state_nxt;
      rd_grant <= rd_grant_nxt;
      rd_prio  <= rd_prio_nxt;
      wr_state <= wr_state_nxt;
      wr_grant <= wr_grant_nxt;
      wr_prio  <= wr_prio_nxt;
    end
  end

  // A lone requester wins outright; a tie goes to the priority bit.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_grant_nxt = rd_grant;
    rd_prio_nxt  = rd_prio;
    case (rd_state)
      R_IDLE: if (s0_axi.arvalid || s1_axi.arvalid) begin
        rd_grant_nxt = (s0_axi.arvalid && s1_axi.arvalid) ? rd_prio : s1_axi.arvalid;
        rd_state_nxt = R_ADDR;
      end
      R_ADDR: if (m_axi.arvalid && m_axi.arready) rd_state_nxt = R_DATA;
      R_DATA: if (m_axi.rvalid && m_axi.rready && m_axi.rlast) begin
        rd_state_nxt = R_IDLE;
        rd_prio_nxt  = ~rd_grant;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_grant_nxt = wr_grant;
    wr_prio_nxt  = wr_prio;
    case (wr_state)
      W_IDLE: if (s0_axi.awvalid || s1_axi.awvalid) begin
        wr_grant_nxt = (s0_axi.awvalid && s1_axi.awvalid) ? wr_prio : s1_axi.awvalid;
        wr_state_nxt = W_ADDR;
      end
      W_ADDR: if (m_axi.awvalid && m_axi.awready) wr_state_nxt = W_DATA;
      W_DATA: if (m_axi.wvalid && m_axi.wready && m_axi.wlast) wr_state_nxt = W_RESP;
      W_RESP: if (m_axi.bvalid && m_axi.bready) begin
        wr_state_nxt = W_IDLE;
        wr_prio_nxt  = ~wr_grant;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    m_axi.araddr   = '0;
    m_axi.arlen    = '0;
    m_axi.arsize   = '0;
    m_axi.arburst  = '0;
    m_axi.arvalid  = 1'b0;
    m_axi.rready   = 1'b0;
    s0_axi.arready = 1'b0;
    s0_axi.rvalid  = 1'b0;
    s0_axi.rdata   = '0;
    s0_axi.rresp   = '0;
    s0_axi.rlast   = 1'b0;
    s1_axi.arready = 1'b0;
    s1_axi.rvalid  = 1'b0;
    s1_axi.rdata   = '0;
    s1_axi.rresp   = '0;
    s1_axi.rlast   = 1'b0;
    if (rd_state == R_ADDR) begin
      if (rd_grant) begin
        m_axi.araddr   = s1_axi.araddr;
        m_axi.arlen    = s1_axi.arlen;
        m_axi.arsize   = s1_axi.arsize;
        m_axi.arburst  = s1_axi.arburst;
        m_axi.arvalid  = s1_axi.arvalid;
        s1_axi.arready = m_axi.arready;
      end else begin
        m_axi.araddr   = s0_axi.araddr;
        m_axi.arlen    = s0_axi.arlen;
        m_axi.arsize   = s0_axi.arsize;
        m_axi.arburst  = s0_axi.arburst;
        m_axi.arvalid  = s0_axi.arvalid;
        s0_axi.arready = m_axi.arready;
      end
    end
    if (rd_state == R_DATA) begin
      if (rd_grant) begin
        m_axi.rready  = s1_axi.rready;
        s1_axi.rvalid = m_axi.rvalid;
        s1_axi.rdata  = m_axi.rdata;
        s1_axi.rresp  = m_axi.rresp;
        s1_axi.rlast  = m_axi.rlast;
      end else begin
        m_axi.rready  = s0_axi.rready;
        s0_axi.rvalid = m_axi.rvalid;
        s0_axi.rdata  = m_axi.rdata;
        s0_axi.rresp  = m_axi.rresp;
        s0_axi.rlast  = m_axi.rlast;
      end
    end
  end

  // Early W beats stall here: wready only reaches a requester in W_DATA.
  always_comb begin
    m_axi.awaddr   = '0;
    m_axi.awlen    = '0;
    m_axi.awsize   = '0;
    m_axi.awburst  = '0;
    m_axi.awvalid  = 1'b0;
    m_axi.wdata    = '0;
    m_axi.wstrb    = '0;
    m_axi.wlast    = 1'b0;
    m_axi.wvalid   = 1'b0;
    m_axi.bready   = 1'b0;
    s0_axi.awready = 1'b0;
    s0_axi.wready  = 1'b0;
    s0_axi.bvalid  = 1'b0;
    s0_axi.bresp   = '0;
    s1_axi.awready = 1'b0;
    s1_axi.wready  = 1'b0;
    s1_axi.bvalid  = 1'b0;
    s1_axi.bresp   = '0;
    case (wr_state)
      W_ADDR: if (wr_grant) begin
        m_axi.awaddr   = s1_axi.awaddr;
        m_axi.awlen    = s1_axi.awlen;
        m_axi.awsize   = s1_axi.awsize;
        m_axi.awburst  = s1_axi.awburst;
        m_axi.awvalid  = s1_axi.awvalid;
        s1_axi.awready = m_axi.awready;
      end else begin
        m_axi.awaddr   = s0_axi.awaddr;
        m_axi.awlen    = s0_axi.awlen;
        m_axi.awsize   = s0_axi.awsize;
        m_axi.awburst  = s0_axi.awburst;
        m_axi.awvalid  = s0_axi.awvalid;
        s0_axi.awready = m_axi.awready;
      end
      W_DATA: if (wr_grant) begin
        m_axi.wdata   = s1_axi.wdata;
        m_axi.wstrb   = s1_axi.wstrb;
        m_axi.wlast   = s1_axi.wlast;
        m_axi.wvalid  = s1_axi.wvalid;
        s1_axi.wready = m_axi.wready;
      end else begin
        m_axi.wdata   = s0_axi.wdata;
        m_axi.wstrb   = s0_axi.wstrb;
        m_axi.wlast   = s0_axi.wlast;
        m_axi.wvalid  = s0_axi.wvalid;
        s0_axi.wready = m_axi.wready;
      end
      W_RESP: if (wr_grant) begin
        m_axi.bready  = s1_axi.bready;
        s1_axi.bvalid = m_axi.bvalid;
        s1_axi.bresp  = m_axi.bresp;
      end else begin
        m_axi.bready  = s0_axi.bready;
        s0_axi.bvalid = m_axi.bvalid;
        s0_axi.bresp  = m_axi.bresp;
      end
      default: ;
    endcase
  end

  assign rd_busy  = (rd_state != R_IDLE);
  assign rd_owner = rd_grant;
  assign wr_busy  = (wr_state != W_IDLE);
  assign wr_owner = wr_grant;

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// tb/tb_axi_arbiter_2to1.sv - directed vector bench for axi_arbiter_2to1
module tb_axi_arbiter_2to1;
  logic aclk = 1'b0;
  logic areset_n;
  logic rd_busy, rd_owner, wr_busy, wr_owner;
  int total = 0;
  int bad = 0;

  axi_if s0_axi ();
  axi_if s1_axi ();
  axi_if m_axi ();

  axi_arbiter_2to1 #(.DEFAULT_PRIO(1'b0)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s0_axi(s0_axi), .s1_axi(s1_axi), .m_axi(m_axi),
    .rd_busy(rd_busy), .rd_owner(rd_owner), .wr_busy(wr_busy), .wr_owner(wr_owner)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic s0_arv, s1_arv, ar_rdy, r_v;
    logic [31:0] r_data;
    logic r_last, s0_rr;
    logic e_m_arv;
    logic [31:0] e_araddr;
    logic e_s0_arr, e_s0_rv;
    logic [31:0] e_s0_rdata;
    logic e_s0_rlast, e_s1_rv, e_m_rr, e_busy;
  } rd_vec_t;

  rd_vec_t vec [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s0_axi.araddr = '0; s0_axi.arlen = '0; s0_axi.arsize = 3'd2; s0_axi.arburst = 2'd1;
    s0_axi.arvalid = 0; s0_axi.rready = 0; s0_axi.awaddr = '0; s0_axi.awlen = '0;
    s0_axi.awsize = 3'd2; s0_axi.awburst = 2'd1; s0_axi.awvalid = 0; s0_axi.wdata = '0;
    s0_axi.wstrb = '0; s0_axi.wlast = 0; s0_axi.wvalid = 0; s0_axi.bready = 0;
    s1_axi.araddr = '0; s1_axi.arlen = '0; s1_axi.arsize = 3'd2; s1_axi.arburst = 2'd1;
    s1_axi.arvalid = 0; s1_axi.rready = 0; s1_axi.awaddr = '0; s1_axi.awlen = '0;
    s1_axi.awsize = 3'd2; s1_axi.awburst = 2'd1; s1_axi.awvalid = 0; s1_axi.wdata = '0;
    s1_axi.wstrb = '0; s1_axi.wlast = 0; s1_axi.wvalid = 0; s1_axi.bready = 0;
    m_axi.arready = 0; m_axi.rdata = '0; m_axi.rresp = '0; m_axi.rlast = 0; m_axi.rvalid = 0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bresp = '0; m_axi.bvalid = 0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
  endtask

  initial begin
    logic exp_w;
    logic [1:0] order;
    int rem [2];
    order = 2'b00;

    //          s0a s1a ardy rv  rdata  rl s0rr | marv araddr s0ar s0rv s0rdata s0rl s1rv mrr busy
    vec[0] = '{1, 0, 0, 0, 32'h0,  0, 0,   0, 32'h0, 0, 0, 32'h0,  0, 0, 0, 0};
    vec[1] = '{1, 0, 1, 0, 32'h0,  0, 0,   1, 32'h4, 1, 0, 32'h0,  0, 0, 0, 1};
    vec[2] = '{0, 0, 0, 1, 32'hA0, 0, 1,   0, 32'h0, 0, 1, 32'hA0, 0, 0, 1, 1};
    vec[3] = '{0, 0, 0, 1, 32'hA1, 0, 0,   0, 32'h0, 0, 1, 32'hA1, 0, 0, 0, 1};
    vec[4] = '{0, 0, 0, 1, 32'hA1, 0, 1,   0, 32'h0, 0, 1, 32'hA1, 0, 0, 1, 1};
    vec[5] = '{0, 0, 0, 1, 32'hA2, 0, 1,   0, 32'h0, 0, 1, 32'hA2, 0, 0, 1, 1};
    vec[6] = '{0, 0, 0, 1, 32'hA3, 1, 1,   0, 32'h0, 0, 1, 32'hA3, 1, 0, 1, 1};
    vec[7] = '{0, 0, 0, 0, 32'h0,  0, 0,   0, 32'h0, 0, 0, 32'h0,  0, 0, 0, 0};
    vec[8] = '{0, 0, 0, 0, 32'h0,  0, 0,   0, 32'h0, 0, 0, 32'h0,  0, 0, 0, 0};

    do_reset();
    #1;
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_owner", rd_owner, 0);
    chk("rst_wr_owner", wr_owner, 0);
    chk("rst_m_arvalid", m_axi.arvalid, 0);
    chk("rst_m_awvalid", m_axi.awvalid, 0);
    chk("rst_m_wvalid", m_axi.wvalid, 0);

    // single 4-beat read from s0, including one stalled beat
    s0_axi.araddr = 32'h4; s0_axi.arlen = 8'd3; s1_axi.araddr = 32'h100;
    for (int i = 0; i < 9; i++) begin
      s0_axi.arvalid = vec[i].s0_arv; s1_axi.arvalid = vec[i].s1_arv;
      m_axi.arready = vec[i].ar_rdy; m_axi.rvalid = vec[i].r_v; m_axi.rdata = vec[i].r_data;
      m_axi.rlast = vec[i].r_last; s0_axi.rready = vec[i].s0_rr;
      #1;
      chk($sformatf("v%0d_m_arvalid", i), m_axi.arvalid, vec[i].e_m_arv);
      chk($sformatf("v%0d_m_araddr", i), m_axi.araddr, vec[i].e_araddr);
      chk($sformatf("v%0d_s0_arready", i), s0_axi.arready, vec[i].e_s0_arr);
      chk($sformatf("v%0d_s0_rvalid", i), s0_axi.rvalid, vec[i].e_s0_rv);
      chk($sformatf("v%0d_s0_rdata", i), s0_axi.rdata, vec[i].e_s0_rdata);
      chk($sformatf("v%0d_s0_rlast", i), s0_axi.rlast, vec[i].e_s0_rlast);
      chk($sformatf("v%0d_s1_rvalid", i), s1_axi.rvalid, vec[i].e_s1_rv);
      chk($sformatf("v%0d_m_rready", i), m_axi.rready, vec[i].e_m_rr);
      chk($sformatf("v%0d_rd_busy", i), rd_busy, vec[i].e_busy);
      chk($sformatf("v%0d_rd_owner", i), rd_owner, 0);
      @(negedge aclk);
    end

    // simultaneous reads, two each: grant order 0,1,0,1
    do_reset();
    s0_axi.araddr = 32'h4; s1_axi.araddr = 32'h100;
    s0_axi.rready = 1; s1_axi.rready = 1;
    s0_axi.arvalid = 1; s1_axi.arvalid = 1;
    rem[0] = 2; rem[1] = 2;
    #1 chk("sim_idle_arvalid", m_axi.arvalid, 0);
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 1);
      @(negedge aclk);
      m_axi.arready = 1;
      #1;
      chk($sformatf("sim%0d_m_arvalid", k), m_axi.arvalid, 1);
      chk($sformatf("sim%0d_m_araddr", k), m_axi.araddr, exp_w ? 32'h100 : 32'h4);
      chk($sformatf("sim%0d_rd_owner", k), rd_owner, exp_w);
      @(negedge aclk);
      rem[exp_w]--;
      if (exp_w) s1_axi.arvalid = (rem[1] > 0); else s0_axi.arvalid = (rem[0] > 0);
      m_axi.arready = 0; m_axi.rvalid = 1; m_axi.rdata = 32'hB0 + k; m_axi.rlast = 1;
      #1;
      chk($sformatf("sim%0d_win_rvalid", k), exp_w ? s1_axi.rvalid : s0_axi.rvalid, 1);
      chk($sformatf("sim%0d_win_rdata", k), exp_w ? s1_axi.rdata : s0_axi.rdata, 32'hB0 + k);
      chk($sformatf("sim%0d_lose_rvalid", k), exp_w ? s0_axi.rvalid : s1_axi.rvalid, 0);
      chk($sformatf("sim%0d_no_ar_mid", k), m_axi.arvalid, 0);
      @(negedge aclk);
      m_axi.rvalid = 0; m_axi.rlast = 0;
      #1 chk($sformatf("sim%0d_idle", k), rd_busy, 0);
    end

    // s1 write burst with W presented alongside AW
    s1_axi.awaddr = 32'h200; s1_axi.awlen = 8'd3; s1_axi.awvalid = 1;
    s1_axi.wvalid = 1; s1_axi.wdata = 32'hDEADBEEF; s1_axi.wstrb = 4'hF; s1_axi.wlast = 0;
    s1_axi.bready = 1;
    #1;
    chk("wr_idle_wready", s1_axi.wready, 0);
    chk("wr_idle_m_wvalid", m_axi.wvalid, 0);
    @(negedge aclk);
    m_axi.awready = 1;
    #1;
    chk("wr_m_awvalid", m_axi.awvalid, 1);
    chk("wr_m_awaddr", m_axi.awaddr, 32'h200);
    chk("wr_s1_awready", s1_axi.awready, 1);
    chk("wr_addr_wready", s1_axi.wready, 0);
    chk("wr_addr_m_wvalid", m_axi.wvalid, 0);
    chk("wr_owner_1", wr_owner, 1);
    @(negedge aclk);
    s1_axi.awvalid = 0; m_axi.awready = 0; m_axi.wready = 1;
    for (int i = 0; i < 4; i++) begin
      s1_axi.wdata = 32'hDEADBEEF + i; s1_axi.wlast = (i == 3);
      #1;
      chk($sformatf("wb%0d_m_wvalid", i), m_axi.wvalid, 1);
      chk($sformatf("wb%0d_m_wdata", i), m_axi.wdata, 32'hDEADBEEF + i);
      chk($sformatf("wb%0d_m_wlast", i), m_axi.wlast, (i == 3));
      chk($sformatf("wb%0d_s1_wready", i), s1_axi.wready, 1);
      chk($sformatf("wb%0d_s0_wready", i), s0_axi.wready, 0);
      @(negedge aclk);
    end
    s1_axi.wvalid = 0; s1_axi.wlast = 0; m_axi.wready = 0;
    m_axi.bvalid = 1; m_axi.bresp = 2'b00;
    #1;
    chk("wr_s1_bvalid", s1_axi.bvalid, 1);
    chk("wr_s1_bresp", s1_axi.bresp, 0);
    chk("wr_s0_bvalid", s0_axi.bvalid, 0);
    chk("wr_m_bready", m_axi.bready, 1);
    chk("wr_resp_wvalid", m_axi.wvalid, 0);
    @(negedge aclk);
    m_axi.bvalid = 0;
    #1 chk("wr_done_busy", wr_busy, 0);

    // concurrent: s0 reads while s1 writes
    s0_axi.arvalid = 1; s0_axi.araddr = 32'h4;
    s1_axi.awvalid = 1; s1_axi.awaddr = 32'h300;
    @(negedge aclk);
    m_axi.arready = 1; m_axi.awready = 1;
    #1;
    chk("cc_rd_busy", rd_busy, 1);
    chk("cc_wr_busy", wr_busy, 1);
    chk("cc_rd_owner", rd_owner, 0);
    chk("cc_wr_owner", wr_owner, 1);
    chk("cc_m_araddr", m_axi.araddr, 32'h4);
    chk("cc_m_awaddr", m_axi.awaddr, 32'h300);
    @(negedge aclk);
    s0_axi.arvalid = 0; s1_axi.awvalid = 0; m_axi.arready = 0; m_axi.awready = 0;
    m_axi.rvalid = 1; m_axi.rdata = 32'hC0; m_axi.rlast = 1;
    s1_axi.wvalid = 1; s1_axi.wdata = 32'h55; s1_axi.wlast = 1; m_axi.wready = 1;
    #1;
    chk("cc_s0_rvalid", s0_axi.rvalid, 1);
    chk("cc_s0_rdata", s0_axi.rdata, 32'hC0);
    chk("cc_s1_rvalid", s1_axi.rvalid, 0);
    chk("cc_s1_rdata", s1_axi.rdata, 0);
    chk("cc_m_wdata", m_axi.wdata, 32'h55);
    chk("cc_s1_wready", s1_axi.wready, 1);
    chk("cc_s0_wready", s0_axi.wready, 0);
    @(negedge aclk);
    m_axi.rvalid = 0; m_axi.rlast = 0; s1_axi.wvalid = 0; s1_axi.wlast = 0; m_axi.wready = 0;
    m_axi.bvalid = 1; m_axi.bresp = 2'b10;
    #1;
    chk("cc_s1_bvalid", s1_axi.bvalid, 1);
    chk("cc_s1_bresp", s1_axi.bresp, 2'b10);
    chk("cc_s0_bvalid", s0_axi.bvalid, 0);
    chk("cc_rd_idle", rd_busy, 0);
    @(negedge aclk);
    m_axi.bvalid = 0; m_axi.bresp = 0;
    #1 chk("cc_wr_idle", wr_busy, 0);

    // reset during beat 2 of an s1 read
    s1_axi.araddr = 32'h100; s1_axi.arvalid = 1; s1_axi.rready = 1;
    @(negedge aclk);
    m_axi.arready = 1;
    @(negedge aclk);
    s1_axi.arvalid = 0; m_axi.arready = 0;
    m_axi.rvalid = 1; m_axi.rdata = 32'hD0; m_axi.rlast = 0;
    #1 chk("mr_beat1", s1_axi.rdata, 32'hD0);
    @(negedge aclk);
    m_axi.rdata = 32'hD1; areset_n = 0;
    #1 chk("mr_beat2", s1_axi.rdata, 32'hD1);
    @(negedge aclk);
    #1;
    chk("mr_rd_busy", rd_busy, 0);
    chk("mr_wr_busy", wr_busy, 0);
    chk("mr_rd_owner", rd_owner, 0);
    chk("mr_m_arvalid", m_axi.arvalid, 0);
    chk("mr_m_rready", m_axi.rready, 0);
    chk("mr_s1_rvalid", s1_axi.rvalid, 0);
    chk("mr_s1_rdata", s1_axi.rdata, 0);
    areset_n = 1; m_axi.rvalid = 0; m_axi.rdata = 0;
    s1_axi.arvalid = 1;
    @(negedge aclk);
    #1;
    chk("mr_regrant_arvalid", m_axi.arvalid, 1);
    chk("mr_regrant_araddr", m_axi.araddr, 32'h100);
    chk("mr_regrant_owner", rd_owner, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
